sha256_t1_accum: RTL
====================

SHA256_T1_ACCUM -- requirements
Module: sha256_t1_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; only 32 is supported.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1 bit: upstream operand set valid.
REQ-005 SHALL have port o_ready, output, 1 bit: block can accept an operand set.
REQ-006 SHALL have ports i_h, i_sigma1, i_ch, i_k, i_w, input, WIDTH bits each: the T1 operands.
REQ-007 SHALL have port o_valid, output, 1 bit: result valid.
REQ-008 SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-009 SHALL have port o_t1, output, WIDTH bits: the result (i_h + i_sigma1 + i_ch + i_k + i_w) mod 2^WIDTH.
REQ-010 SHALL have port o_carries, output, 3 bits: count of carry-outs produced during the four additions (0..4).

Function
REQ-011 SHALL perform all additions through a single instance of the team's 32-bit carry-select adder (adder_csla_cla), with its carry-in tied to 0.
REQ-012 SHALL implement an FSM with states IDLE, ACCUM and DONE, plus a 2-bit step counter and a WIDTH-bit accumulator.
REQ-013 SHALL assert o_ready only in IDLE; o_ready is a registered-state decode and does not depend on i_valid.
REQ-014 SHALL accept an operand set on a rising edge where i_valid && o_ready, and on that edge:
- capture i_sigma1, i_ch, i_k and i_w into holding registers;
- load the accumulator with i_h;
- clear the step counter and o_carries;
- enter ACCUM.
REQ-015 SHALL, in ACCUM on each edge:
- set acc = acc + operand[step], with operand order sigma1, ch, k, w for step 0..3;
- increment o_carries when the adder carry-out is 1;
- increment step.
REQ-016 SHALL enter DONE on the edge that performs step 3, so the fourth edge after acceptance raises o_valid (latency 4 cycles from the accepting edge).
REQ-017 SHALL, in DONE, hold o_valid = 1 with o_t1 = accumulator and o_carries stable until the edge where i_ready = 1; on that edge it returns to IDLE and drops o_valid.
REQ-018 SHALL ignore input operand changes after acceptance; inputs are not sampled in ACCUM or DONE.
REQ-019 SHALL ignore i_valid while not in IDLE; upstream holds its data until accepted.
REQ-020 SHALL NOT accept a new set in the same cycle a result is consumed; the minimum spacing between accepts is 6 cycles.
REQ-021 SHALL ignore i_ready outside DONE; it produces no state change.
REQ-022 SHALL compute modulo 2^WIDTH: the carry out of bit 31 never reaches o_t1 and is reflected only in o_carries, which saturates by construction at 4.
REQ-023 SHALL drive o_t1 = accumulator at all times; o_t1 is meaningful only while o_valid = 1.

Reset
REQ-024 SHALL, while i_rst = 1, asynchronously force: state IDLE, step 0, accumulator 0, o_carries 0, o_valid 0, o_ready 1.
REQ-025 SHALL, when reset asserts mid-ACCUM or in DONE, discard the in-flight operation with no result emitted; after release, the first accepted set computes correctly.
REQ-026 SHALL clear the operand holding registers to 0 on reset.

Verification
REQ-027 SHALL be checked with the all-zero case: all operands 0 -> o_valid 4 cycles after accept, o_t1 = 0x00000000, o_carries = 0.
REQ-028 SHALL be checked with the wrap case: h = 0xFFFFFFFF, others 0x00000001 -> o_t1 = 0x00000003, o_carries = 1.
REQ-029 SHALL be checked with the multi-carry case: all five operands 0x80000000 -> o_t1 = 0x80000000, o_carries = 2.
REQ-030 SHALL be checked with backpressure: i_ready held 0 for 10 cycles in DONE -> o_valid and o_t1 stable, o_ready 0 throughout, and a single consume on the i_ready pulse.
REQ-031 SHALL be checked with reset mid-ACCUM: i_rst pulsed at step 2 -> outputs immediately at reset values and no o_valid; next set h = 1, others 2 -> o_t1 = 0x00000009.
REQ-032 SHALL be checked with back-to-back traffic: i_valid held 1 with 100 random sets and random i_ready -> every result matches a mod-2^32 reference model, in order, with no set lost or duplicated.

Source files
------------

// File: rtl/sha256_t1_accum.sv
// rtl/sha256_t1_accum.sv - SHA-256 T1 five-operand accumulator built around one shared carry-select adder

// 32-bit carry-select adder: eight 4-bit lookahead blocks, each precomputed for carry-in 0 and 1
module adder_csla_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // Block results for both carry-ins are formed in parallel; the ripple only drives the selects
    always_comb begin
        logic       carry;
        logic [4:0] r0;
        logic [4:0] r1;
        logic [4:0] sel;
        sum   = '0;
        carry = cin;
        for (int blk = 0; blk < 8; blk++) begin
            r0    = cla4(a[blk*4 +: 4], b[blk*4 +: 4], 1'b0);
            r1    = cla4(a[blk*4 +: 4], b[blk*4 +: 4], 1'b1);
            sel   = carry ? r1 : r0;
            sum[blk*4 +: 4] = sel[3:0];
            carry = sel[4];
        end
        cout = carry;
    end

endmodule

module sha256_t1_accum #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_sigma1,
    input  logic [WIDTH-1:0] i_ch,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_w,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_t1,
    output logic [2:0]       o_carries
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       step;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] hold_sigma1;
    logic [WIDTH-1:0] hold_ch;
    logic [WIDTH-1:0] hold_k;
    logic [WIDTH-1:0] hold_w;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // Pick the held operand for the current step: sigma1, ch, k, w
    always_comb begin
        operand = hold_sigma1;
        case (step)
            2'd0: operand = hold_sigma1;
            2'd1: operand = hold_ch;
            2'd2: operand = hold_k;
            2'd3: operand = hold_w;
            default: operand = hold_sigma1;
        endcase
    end

    adder_csla_cla u_adder (
        .a    (acc),
        .b    (operand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign o_t1 = acc;

    // Accept in IDLE, fold one operand per cycle in ACCUM, hold the result in DONE until consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            step        <= 2'd0;
            acc         <= '0;
            hold_sigma1 <= '0;
            hold_ch     <= '0;
            hold_k      <= '0;
            hold_w      <= '0;
            o_carries   <= 3'd0;
            o_valid     <= 1'b0;
            o_ready     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        hold_sigma1 <= i_sigma1;
                        hold_ch     <= i_ch;
                        hold_k      <= i_k;
                        hold_w      <= i_w;
                        acc         <= i_h;
                        step        <= 2'd0;
                        o_carries   <= 3'd0;
                        o_ready     <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc       <= add_sum;
                    o_carries <= o_carries + {2'b00, add_cout};
                    step      <= step + 2'd1;
                    if (step == 2'd3) begin
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
